// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared MIPS opcode constants, control-bundle layout and NOP encoding.
package id_ex_stage_pkg;

    localparam int CTRL_WIDTH = 10;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Bit positions inside the packed control bundle, MSB first.
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_TO_REG = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_DST    = 3;
    localparam int CTRL_ALU_OP_HI  = 2;
    localparam int CTRL_ALU_OP_LO  = 0;

    localparam logic [CTRL_WIDTH-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use detection and PC / IF-ID write enables.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       stall_in,
    output logic       load_use_hazard,
    output logic       pc_write_en,
    output logic       if_id_write_en
);

    // rt is compared for every opcode; a spurious bubble is cheaper than a decode here.
    assign load_use_hazard = ex_valid & ex_mem_read & (ex_rt != 5'd0) & id_valid &
                             ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign pc_write_en     = ~(load_use_hazard | stall_in);
    assign if_id_write_en  = pc_write_en;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbling, downstream hold,
// branch flush and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = CTRL_WIDTH,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_ext_immed,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_ext_immed,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              load_use_hazard,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic bubble;

    hazard_detect u_hazard (
        .ex_valid        (ex_valid),
        .ex_mem_read     (ex_ctrl[CTRL_MEM_READ]),
        .ex_rt           (ex_rt),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .stall_in        (stall_in),
        .load_use_hazard (load_use_hazard),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en)
    );

    assign bubble = flush_in | load_use_hazard;

    // Bubbles zero every field, not just valid/ctrl, so waveforms read cleanly.
    always_ff @(posedge clk) begin
        if (rst || (!stall_in && bubble)) begin
            ex_valid     <= 1'b0;
            ex_opcode    <= '0;
            ex_funct     <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_shamt     <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_ext_immed <= '0;
            ex_ctrl      <= CTRL_NOP;
        end else if (!stall_in) begin
            ex_valid     <= id_valid;
            ex_opcode    <= id_opcode;
            ex_funct     <= id_funct;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rd        <= id_rd;
            ex_shamt     <= id_shamt;
            ex_rs_data   <= id_rs_data;
            ex_rt_data   <= id_rt_data;
            ex_ext_immed <= id_ext_immed;
            ex_ctrl      <= id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bubble_cnt <= '0;
        else if (!stall_in && bubble && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 1'b1;
    end

endmodule
